// File: rtl/hub_uplink_arbiter_pkg.sv
// Shared NoC hub definitions: leaf count, flit width, leaf index type.
package hub_uplink_arbiter_pkg;

    localparam int NUM_LEAVES = 4;
    localparam int NOC_FLIT_W = 20;

    typedef logic [1:0] leaf_idx_t;

    // Round-robin pointer value after reset: leaf 0 is searched first.
    localparam leaf_idx_t LAST_GRANT_RST = 2'd3;

endpackage

// File: rtl/leaf_flit_fifo.sv
// Per-leaf flit buffer. A write while full is accepted only if a pop
// frees an entry in the same cycle; otherwise it is ignored.
module leaf_flit_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           cnt;
    logic                    push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign push  = wr_en && (!full || pop);
    assign head  = mem[rd_ptr];

    // Storage array, no reset needed: only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/hub_uplink_arbiter.sv
// Four-leaf uplink arbiter: buffers leaf flits, picks one per cycle in
// round-robin order and forwards it to the super-hub under credit control.
module hub_uplink_arbiter
    import hub_uplink_arbiter_pkg::*;
#(
    parameter int FLIT_W     = NOC_FLIT_W,
    parameter int BUF_DEPTH  = 2,
    parameter int SH_CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LEAVES*FLIT_W-1:0] leaf_data,
    input  logic [NUM_LEAVES-1:0]        leaf_valid,
    output logic [NUM_LEAVES-1:0]        leaf_co,
    output logic [FLIT_W-1:0]            sh_data,
    output logic                         sh_valid,
    input  logic                         sh_ci,
    output logic [1:0]                   grant_id,
    output logic [NUM_LEAVES-1:0]        overflow,
    output logic                         credit_err
);

    localparam int CRW = $clog2(SH_CREDITS + 1);

    logic [NUM_LEAVES-1:0][FLIT_W-1:0] fifo_head;
    logic [NUM_LEAVES-1:0]             fifo_empty, fifo_full;
    logic [NUM_LEAVES-1:0]             eligible, pop, drop;
    logic [CRW-1:0]                    credits;
    leaf_idx_t                         last_grant, grant_sel;
    logic                              grant_vld;

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_leaf
        leaf_flit_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (leaf_valid[g]),
            .wr_data (leaf_data[g*FLIT_W +: FLIT_W]),
            .pop     (pop[g]),
            .head    (fifo_head[g]),
            .empty   (fifo_empty[g]),
            .full    (fifo_full[g])
        );
        // A pop in the same cycle frees the slot, so only drop when not popping.
        assign drop[g] = leaf_valid[g] && fifo_full[g] && !pop[g];
    end

    assign eligible = ~fifo_empty & {NUM_LEAVES{credits != '0}};
    assign pop      = grant_vld ? (NUM_LEAVES'(1) << grant_sel) : '0;

    // Round-robin pick: first eligible leaf after last_grant, wrapping.
    always_comb begin
        leaf_idx_t cand;
        grant_vld = 1'b0;
        grant_sel = last_grant;
        cand      = last_grant;
        for (int k = 1; k <= NUM_LEAVES; k++) begin
            cand = last_grant + leaf_idx_t'(k);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_sel = cand;
            end
        end
    end

    // Super-hub credit counter; a surplus return at full count is an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits    <= CRW'(SH_CREDITS);
            credit_err <= 1'b0;
        end else begin
            case ({grant_vld, sh_ci})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CRW'(SH_CREDITS)) credit_err <= 1'b1;
                    else                             credits    <= credits + 1'b1;
                end
                default: credits <= credits;
            endcase
        end
    end

    // Registered uplink outputs, credit pulses back to leaves, sticky drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_valid   <= 1'b0;
            sh_data    <= '0;
            grant_id   <= '0;
            leaf_co    <= '0;
            overflow   <= '0;
            last_grant <= LAST_GRANT_RST;
        end else begin
            sh_valid <= grant_vld;
            leaf_co  <= pop;
            overflow <= overflow | drop;
            if (grant_vld) begin
                sh_data    <= fifo_head[grant_sel];
                grant_id   <= grant_sel;
                last_grant <= grant_sel;
            end
        end
    end

endmodule

// File: tb/tb_hub_uplink_arbiter.sv
// Bench for hub_uplink_arbiter: directed vector table plus randomized
// traffic compared against a queue-based reference model.
module tb_hub_uplink_arbiter;

    localparam int FW = 20;
    localparam int BD = 2;
    localparam int SH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [4*FW-1:0] leaf_data = '0;
    logic [3:0]      leaf_valid = '0;
    logic            sh_ci = 1'b0;
    logic [3:0]      leaf_co;
    logic [FW-1:0]   sh_data;
    logic            sh_valid;
    logic [1:0]      grant_id;
    logic [3:0]      overflow;
    logic            credit_err;

    hub_uplink_arbiter #(.FLIT_W(FW), .BUF_DEPTH(BD), .SH_CREDITS(SH)) dut (
        .clk        (clk),
        .rst        (rst),
        .leaf_data  (leaf_data),
        .leaf_valid (leaf_valid),
        .leaf_co    (leaf_co),
        .sh_data    (sh_data),
        .sh_valid   (sh_valid),
        .sh_ci      (sh_ci),
        .grant_id   (grant_id),
        .overflow   (overflow),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per leaf, an integer credit pool.
    logic [FW-1:0] q[4][$];
    int            cred;
    int            last;
    logic          m_v;
    logic [1:0]    m_id;
    logic [FW-1:0] m_d;
    logic [3:0]    m_co;
    logic [3:0]    m_ovf;
    logic          m_cerr;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        cred = SH; last = 3;
        m_v = 0; m_id = 0; m_d = 0; m_co = 0; m_ovf = 0; m_cerr = 0;
    endtask

    // One clock edge of the model, using the inputs present before the edge.
    task automatic model_step();
        int g = -1;
        if (cred > 0)
            for (int k = 1; k <= 4; k++) begin
                int c = (last + k) % 4;
                if (g < 0 && q[c].size() > 0) g = c;
            end
        m_co = 0;
        m_v  = (g >= 0);
        if (g >= 0) begin
            m_d = q[g].pop_front();
            m_id = g[1:0];
            m_co[g] = 1'b1;
            last = g;
        end
        for (int i = 0; i < 4; i++)
            if (leaf_valid[i]) begin
                if (q[i].size() < BD) q[i].push_back(leaf_data[i*FW +: FW]);
                else                  m_ovf[i] = 1'b1;
            end
        if (g >= 0 && !sh_ci) cred--;
        else if (g < 0 && sh_ci) begin
            if (cred == SH) m_cerr = 1'b1;
            else            cred++;
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [1:0] eid,
                             input logic [FW-1:0] ed, input logic [3:0] eco,
                             input logic [3:0] eovf, input logic ecerr);
        checks++;
        if (sh_valid !== ev || grant_id !== eid || sh_data !== ed || leaf_co !== eco ||
            overflow !== eovf || credit_err !== ecerr) begin
            errors++;
            $display("FAIL %s: got v=%0b id=%0d d=%h co=%b ovf=%b cerr=%0b, expected v=%0b id=%0d d=%h co=%b ovf=%b cerr=%0b",
                     name, sh_valid, grant_id, sh_data, leaf_co, overflow, credit_err,
                     ev, eid, ed, eco, eovf, ecerr);
        end
    endtask

    // Called at a falling edge; holds reset one full cycle.
    task automatic do_reset();
        rst = 1'b0; leaf_valid = '0; sh_ci = 1'b0; leaf_data = '0;
        #1 check_out("reset_assert", 0, 0, '0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check_out("reset_hold", 0, 0, '0, 0, 0, 0);
        rst = 1'b1;
    endtask

    // Apply one cycle of inputs, advance the model, compare at the next falling edge.
    task automatic drive(input logic [3:0] vld, input logic [4*FW-1:0] d, input logic ci);
        leaf_valid = vld; leaf_data = d; sh_ci = ci;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out("model", m_v, m_id, m_d, m_co, m_ovf, m_cerr);
    endtask

    typedef struct {
        bit              rst_b;
        logic [3:0]      vld;
        logic [4*FW-1:0] d;
        logic            ci;
        logic            ev;
        logic [1:0]      eid;
        logic [FW-1:0]   ed;
        logic [3:0]      eco;
        logic [3:0]      eovf;
        logic            ecerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [3:0] vld, logic [4*FW-1:0] d, logic ci,
                                logic ev, logic [1:0] eid, logic [FW-1:0] ed,
                                logic [3:0] eco, logic [3:0] eovf, logic ecerr);
        vec_t v;
        v.rst_b = r; v.vld = vld; v.d = d; v.ci = ci; v.ev = ev; v.eid = eid;
        v.ed = ed; v.eco = eco; v.eovf = eovf; v.ecerr = ecerr;
        return v;
    endfunction

    function automatic logic [4*FW-1:0] ld(int i, logic [FW-1:0] v);
        logic [4*FW-1:0] r = '0;
        r[i*FW +: FW] = v;
        return r;
    endfunction

    initial begin
        logic [4*FW-1:0] fair;
        fair = {20'h10003, 20'h10002, 20'h10001, 20'h10000};
        // Single flit from leaf 2, then surplus credit return -> credit_err.
        tbl.push_back(mk(1, 4'b0100, ld(2, 20'h12345), 0, 0, 0, 20'h0,     4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,               0, 1, 2, 20'h12345, 4'b0100, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,               0, 0, 2, 20'h12345, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,               1, 0, 2, 20'h12345, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,               1, 0, 2, 20'h12345, 4'b0000, 4'b0, 1));
        // Fairness: all four at once, grants 0..3, credits drained.
        tbl.push_back(mk(1, 4'b1111, fair, 0, 0, 0, 20'h0,     4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,   0, 1, 0, 20'h10000, 4'b0001, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,   0, 1, 1, 20'h10001, 4'b0010, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,   0, 1, 2, 20'h10002, 4'b0100, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0,   0, 1, 3, 20'h10003, 4'b1000, 4'b0, 0));
        // Credit stall: flits 5 and 6 each wait for a credit return.
        tbl.push_back(mk(0, 4'b0001, ld(0, 20'h20000), 0, 0, 3, 20'h10003, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0001, ld(0, 20'h20001), 0, 0, 3, 20'h10003, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 1, 0, 3, 20'h10003, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 1, 0, 20'h20000, 4'b0001, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 0, 0, 20'h20000, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 1, 0, 0, 20'h20000, 4'b0000, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 1, 0, 20'h20001, 4'b0001, 4'b0, 0));
        // Overflow: three flits into a two-entry buffer with no credit.
        tbl.push_back(mk(0, 4'b0010, ld(1, 20'h30000), 0, 0, 0, 20'h20001, 4'b0000, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0010, ld(1, 20'h30001), 0, 0, 0, 20'h20001, 4'b0000, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0010, ld(1, 20'h30002), 0, 0, 0, 20'h20001, 4'b0000, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 1, 0, 0, 20'h20001, 4'b0000, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 1, 1, 20'h30000, 4'b0010, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 1, 0, 1, 20'h30000, 4'b0000, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 1, 1, 20'h30001, 4'b0010, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 0, 1, 20'h30001, 4'b0000, 4'b0010, 0));
        // Grant and credit return together keep one credit for a second grant.
        tbl.push_back(mk(0, 4'b1000, ld(3, 20'h40000), 1, 0, 1, 20'h30001, 4'b0000, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b1000, ld(3, 20'h40001), 1, 1, 3, 20'h40000, 4'b1000, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 1, 3, 20'h40001, 4'b1000, 4'b0010, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 0, 3, 20'h40001, 4'b0000, 4'b0010, 0));
        // Reset with two flits buffered: nothing emerges afterwards.
        tbl.push_back(mk(1, 4'b0011, {40'h0, 20'h50001, 20'h50000}, 0, 0, 0, 20'h0, 4'b0, 4'b0, 0));
        tbl.push_back(mk(1, 4'b0000, '0, 0, 0, 0, 20'h0, 4'b0, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 0, 0, 20'h0, 4'b0, 4'b0, 0));
        tbl.push_back(mk(0, 4'b0000, '0, 0, 0, 0, 20'h0, 4'b0, 4'b0, 0));

        @(negedge clk);
        foreach (tbl[n]) begin
            if (tbl[n].rst_b) do_reset();
            drive(tbl[n].vld, tbl[n].d, tbl[n].ci);
            check_out($sformatf("vec%0d", n), tbl[n].ev, tbl[n].eid, tbl[n].ed,
                      tbl[n].eco, tbl[n].eovf, tbl[n].ecerr);
        end

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [3:0]      v;
            logic [4*FW-1:0] d;
            if ($urandom_range(0, 299) == 0) do_reset();
            v = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            d = {20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)};
            drive(v, d, ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
